// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: drives the RX edge/bit counter, majority-samples rx_in,
// deserialises LSB first and checks parity/stop bits, reporting one byte per good frame.
`timescale 1ns/1ps
module uart_rx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [5:0]            prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [5:0]            edge_cnt,
    input  logic [5:0]            bit_cnt,
    output logic                  cnt_enable,
    output logic                  cnt_done,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stop_err,
    output logic                  busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [5:0] LAST_DATA_BIT = 6'(DATA_WIDTH);

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  s0, s1, s2;
    logic                  par_en_q, par_typ_q, par_flag;
    logic [5:0]            mid;
    logic                  end_of_bit;
    logic                  bit_val;

    always_comb begin
        mid        = prescale >> 1;
        end_of_bit = cnt_enable && (edge_cnt == prescale - 6'd1);
        bit_val    = (s0 & s1) | (s0 & s2) | (s1 & s2);
    end

    // Three samples straddling mid-bit; the vote is only consumed at end_of_bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else if (cnt_enable) begin
            if (edge_cnt == mid - 6'd1) s0 <= rx_in;
            if (edge_cnt == mid)        s1 <= rx_in;
            if (edge_cnt == mid + 6'd1) s2 <= rx_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_flag   <= 1'b0;
            cnt_enable <= 1'b0;
            cnt_done   <= 1'b0;
            p_data     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stop_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            cnt_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_in) begin
                        par_en_q   <= par_en;
                        par_typ_q  <= par_typ;
                        par_flag   <= 1'b0;
                        cnt_enable <= 1'b1;
                        busy       <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    if (end_of_bit) begin
                        if (!bit_val) begin
                            state <= DATA;
                        end else begin
                            cnt_enable <= 1'b0;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (end_of_bit) begin
                        shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
                        if (bit_cnt == LAST_DATA_BIT)
                            state <= par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (end_of_bit) begin
                        par_flag <= bit_val ^ (^shift_reg) ^ par_typ_q;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (end_of_bit) begin
                        par_err  <= par_flag;
                        stop_err <= ~bit_val;
                        if (!par_flag && bit_val) begin
                            p_data     <= shift_reg;
                            data_valid <= 1'b1;
                        end
                        cnt_done   <= 1'b1;
                        cnt_enable <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl with a behavioural edge/bit counter alongside.
`timescale 1ns/1ps
module tb_uart_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic [5:0] prescale;
    logic       par_en, par_typ;
    logic [5:0] edge_cnt, bit_cnt;
    logic       cnt_enable, cnt_done;
    logic [7:0] p_data;
    logic       data_valid, par_err, stop_err, busy;

    typedef struct {
        logic [7:0] pdata;
        logic       dv;
        logic       pe;
        logic       se;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [7:0] last_good = 8'h00;
    int         checks = 0;
    int         errors = 0;
    int         dv_count = 0;
    int         exp_dv = 0;

    uart_rx_frame_ctrl #(.DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale),
        .par_en(par_en), .par_typ(par_typ), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
        .cnt_enable(cnt_enable), .cnt_done(cnt_done), .p_data(p_data),
        .data_valid(data_valid), .par_err(par_err), .stop_err(stop_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Upstream counter behaviour the controller expects.
    always @(posedge clk or negedge rst) begin
        if (!rst || !cnt_enable) begin
            edge_cnt <= 6'd0;
            bit_cnt  <= 6'd0;
        end else if (edge_cnt == prescale - 6'd1) begin
            edge_cnt <= 6'd0;
            bit_cnt  <= bit_cnt + 6'd1;
        end else begin
            edge_cnt <= edge_cnt + 6'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (data_valid === 1'b1) dv_count++;
            if (cnt_done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_cnt_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("data_valid", 32'(data_valid), 32'(e.dv));
                    check("p_data",     32'(p_data),     32'(e.pdata));
                    check("par_err",    32'(par_err),    32'(e.pe));
                    check("stop_err",   32'(stop_err),   32'(e.se));
                end
            end else if (data_valid === 1'b1) begin
                check("dv_without_done", 1, 0);
            end
        end
    end

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int ps, input int gbit);
        for (int c = 0; c < ps; c++) begin
            rx_in = (gbit != 0 && bit_cnt == 6'(gbit) && edge_cnt == 6'(ps >> 1)) ? ~b : b;
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int ps, input logic pe, input logic pt,
                              input logic pbit, input logic sbit, input int gbit);
        logic perr;
        logic good;
        prescale = 6'(ps);
        par_en   = pe;
        par_typ  = pt;
        perr = pe && (pbit ^ (^d) ^ pt);
        good = !perr && sbit;
        if (good) begin
            last_good = d;
            exp_dv++;
        end
        sb.push_back('{pdata: last_good, dv: good, pe: perr, se: !sbit});
        send_bit(1'b0, ps, 0);
        for (int i = 0; i < 8; i++) send_bit(d[i], ps, gbit);
        if (pe) send_bit(pbit, ps, 0);
        send_bit(sbit, ps, 0);
    endtask

    task automatic settle();
        int n;
        rx_in = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("busy_after_frame", 32'(busy), 0);
        check("sb_drained", 32'(sb.size()), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; rx_in = 1'b1; prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_p_data", 32'(p_data), 0);
        check("rst_data_valid", 32'(data_valid), 0);
        check("rst_par_err", 32'(par_err), 0);
        check("rst_stop_err", 32'(stop_err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_cnt_enable", 32'(cnt_enable), 0);
        check("rst_cnt_done", 32'(cnt_done), 0);
        rst = 1'b1;
        idle(3);

        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        settle();
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        settle();
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 0);
        settle();
        send_frame(8'h01, 32, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        settle();

        // False start: three low cycles, then back to idle.
        prescale = 6'd16; par_en = 1'b0;
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        rx_in = 1'b1;
        @(negedge clk);
        check("abort_busy_high", 32'(busy), 1);
        idle(25);
        check("abort_busy_low", 32'(busy), 0);
        check("abort_par_err", 32'(par_err), 0);
        check("abort_stop_err", 32'(stop_err), 1);
        check("abort_dv_count", 32'(dv_count), 32'(exp_dv));

        send_frame(8'h96, 16, 1'b0, 1'b0, 1'b0, 1'b1, 4);
        settle();

        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        send_frame(8'hAA, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        settle();

        // Third frame abandoned by reset partway through its data bits.
        send_bit(1'b0, 8, 0);
        send_bit(1'b1, 8, 0);
        send_bit(1'b1, 8, 0);
        send_bit(1'b0, 8, 0);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_p_data", 32'(p_data), 0);
        check("mid_rst_data_valid", 32'(data_valid), 0);
        check("mid_rst_par_err", 32'(par_err), 0);
        check("mid_rst_stop_err", 32'(stop_err), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_cnt_enable", 32'(cnt_enable), 0);
        check("mid_rst_cnt_done", 32'(cnt_done), 0);
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(40);
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_p_data", 32'(p_data), 0);
        check("dv_total", 32'(dv_count), 32'(exp_dv));
        check("sb_final", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Receive-side frame controller for the UART. It sits directly downstream of the RX edge/bit counter: it consumes that counter's edge and bit counts, drives its enable and done inputs, majority-samples the serial line, deserialises the data bits LSB first, and checks parity and stop bits. Its output is a parallel byte with a one-cycle valid pulse, plus sticky-per-frame error flags, passed to the ALU/command side.

Parameters:
DATA_WIDTH, 8, number of data bits per frame; the exit from DATA compares against bit_cnt, so DATA_WIDTH plus the parity and stop bits must stay below 64.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
rx_in  input  1  serial line, already synchronised to clk, idles high
prescale  input  6  oversampling ratio (8, 16 or 32); static while busy=1
par_en  input  1  parity bit present; latched at start detect
par_typ  input  1  0 = even, 1 = odd; latched at start detect
edge_cnt  input  6  from the counter: 0..prescale-1 within the current bit
bit_cnt  input  6  from the counter: 0 = start bit, 1..DATA_WIDTH = data bits, then parity, then stop
cnt_enable  output  1  enable to the counter; low clears the counter
cnt_done  output  1  one-cycle pulse to the counter at frame end
p_data  output  DATA_WIDTH  received byte
data_valid  output  1  one-cycle pulse when p_data is updated
par_err  output  1  parity result of the last completed frame
stop_err  output  1  stop-bit result of the last completed frame
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=0): state=IDLE; all outputs 0; shift register, sample registers and latched config cleared. Reset mid-frame abandons the frame; no data_valid is produced.
- Definitions: mid = prescale>>1. end_of_bit = cnt_enable && edge_cnt == prescale-1.
- Sampling: whenever cnt_enable=1, rx_in is registered into s0 at edge_cnt==mid-1, s1 at edge_cnt==mid, and s2 at edge_cnt==mid+1. bit_val = majority(s0,s1,s2). bit_val is used only at end_of_bit.
- States and transitions:
  - IDLE: cnt_enable=0. If rx_in==0: latch par_en/par_typ and go to START. cnt_enable is registered, so it is 1 from the next cycle.
  - START: at end_of_bit, bit_val==0 -> DATA. bit_val==1 is a glitch -> IDLE, with no flags changed and no pulse.
  - DATA: at each end_of_bit, shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]} (LSB first). At the end_of_bit where bit_cnt==DATA_WIDTH: go to PARITY if the latched par_en=1, else STOP.
  - PARITY: at end_of_bit, par_flag <= bit_val XOR (^shift_reg) XOR par_typ. Go to STOP.
  - STOP: at end_of_bit:
    - par_err <= par_flag (0 when parity is disabled); stop_err <= ~bit_val.
    - If no error: p_data <= shift_reg and data_valid=1 for exactly one cycle.
    - cnt_done=1 for that same cycle; cnt_enable drops; go to IDLE.
- Outputs are all registered, so data_valid and cnt_done assert in the cycle after the final end_of_bit.
- p_data holds its value until the next error-free frame.
- par_err and stop_err are updated only at frame end and hold until then.
- Back-to-back frames: IDLE samples rx_in in the first cycle after STOP exits. A start bit arriving immediately after the stop bit is accepted with at most 2 cycles of skew, which is tolerated since prescale >= 8.
- Simultaneous events: rx_in changes while in any non-IDLE state are ignored except through the s0/s1/s2 samples. A change of prescale while busy=1 is undefined behaviour and is not a supported configuration.
- Counter contract: edge_cnt wraps to 0 and bit_cnt increments on the cycle after edge_cnt == prescale-1; both are 0 while cnt_enable=0.

Test Plan:
- prescale=8, par_en=0, frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> p_data=0xA5, data_valid pulses once, par_err=0, stop_err=0, busy returns to 0.
- prescale=16, par_en=1, par_typ=0, 0x3C with parity bit 0 -> p_data=0x3C, no errors; repeat with parity bit 1 -> par_err=1, no data_valid, p_data keeps 0x3C.
- prescale=32, par_typ=1, 0x01 with parity 0 and stop bit 0 -> stop_err=1, par_err=0, no data_valid, cnt_done still pulses.
- rx_in low for 3 cycles at prescale=16, then high -> START aborts to IDLE at end_of_bit, no data_valid, flags unchanged.
- Single-cycle glitch at edge_cnt==mid on one data bit -> majority rejects it and the byte is received correctly.
- Two back-to-back frames 0x55 then 0xAA at prescale=8; then assert rst mid-data of a third frame -> two data_valid pulses with the correct bytes; after reset all outputs are 0, state is IDLE, no third pulse.
